// File: rtl/beverage_vend_ctrl.sv
// Vending transaction sequencer: collects coins into a credit counter,
// validates a product selection against price and stock, drives the
// dispenser handshake and pays leftover credit back in 50-cent units.
module beverage_vend_ctrl #(
    parameter int PRICE_UNITS  = 3,
    parameter int MAX_UNITS    = 6,
    parameter int NUM_PRODUCTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              coin,
    input  logic                    cancel,
    input  logic                    sel_valid,
    input  logic [1:0]              sel_id,
    input  logic [NUM_PRODUCTS-1:0] stock_empty,
    input  logic                    disp_ack,
    input  logic                    chg_ack,
    output logic                    disp_req,
    output logic [1:0]              disp_id,
    output logic                    chg_req,
    output logic                    coin_reject,
    output logic                    sel_err,
    output logic [2:0]              credit,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CREDIT = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    logic [1:0] state, state_nxt;
    logic [2:0] credit_q, credit_nxt;
    logic [1:0] disp_id_q, disp_id_nxt;
    logic       coin_reject_q, coin_reject_nxt;
    logic       sel_err_q, sel_err_nxt;

    logic [3:0] empty_pad;
    logic [1:0] coin_val;
    logic [3:0] coin_sum;
    logic       cancel_take;
    logic       sel_ok;

    // Decode coin value, pad stock flags (missing products read as empty),
    // and evaluate cancel / selection acceptance on the registered credit.
    always_comb begin
        empty_pad = 4'b1111;
        empty_pad[NUM_PRODUCTS-1:0] = stock_empty;
        case (coin)
            2'b01:   coin_val = 2'd1;
            2'b10:   coin_val = 2'd2;
            default: coin_val = 2'd0;
        endcase
        // 4-bit sum so a near-full credit cannot wrap past the limit check
        coin_sum    = {1'b0, credit_q} + {2'b00, coin_val};
        cancel_take = (state == S_CREDIT) && cancel;
        sel_ok      = (state == S_CREDIT) && sel_valid && !cancel &&
                      (credit_q >= 3'(PRICE_UNITS)) && !empty_pad[sel_id];
    end

    // Next-state, credit and pulse-output computation.
    always_comb begin
        state_nxt       = state;
        credit_nxt      = credit_q;
        disp_id_nxt     = disp_id_q;
        coin_reject_nxt = 1'b0;
        sel_err_nxt     = 1'b0;
        case (state)
            S_IDLE, S_CREDIT: begin
                // IDLE refuses any selection; CREDIT refuses it unless cancel wins
                if (sel_valid && ((state == S_IDLE) || (!cancel && !sel_ok)))
                    sel_err_nxt = 1'b1;
                if (coin == 2'b11) begin
                    coin_reject_nxt = 1'b1;
                end else if (coin_val != 2'd0) begin
                    // a coin arriving alongside a vend or cancel goes back to the customer
                    if (sel_ok || cancel_take) begin
                        coin_reject_nxt = 1'b1;
                    end else if (coin_sum <= 4'(MAX_UNITS)) begin
                        credit_nxt = coin_sum[2:0];
                        state_nxt  = S_CREDIT;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end
                if (sel_ok) begin
                    credit_nxt  = credit_q - 3'(PRICE_UNITS);
                    disp_id_nxt = sel_id;
                    state_nxt   = S_VEND;
                end else if (cancel_take) begin
                    state_nxt = S_CHANGE;
                end
            end
            S_VEND: begin
                coin_reject_nxt = (coin != 2'b00);
                if (disp_ack)
                    state_nxt = (credit_q != 3'd0) ? S_CHANGE : S_IDLE;
            end
            default: begin
                coin_reject_nxt = (coin != 2'b00);
                if (chg_ack) begin
                    credit_nxt = credit_q - 3'd1;
                    if (credit_q == 3'd1)
                        state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any transaction and drops credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            credit_q      <= 3'd0;
            disp_id_q     <= 2'd0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit_q      <= credit_nxt;
            disp_id_q     <= disp_id_nxt;
            coin_reject_q <= coin_reject_nxt;
            sel_err_q     <= sel_err_nxt;
        end
    end

    assign disp_req    = (state == S_VEND);
    assign chg_req     = (state == S_CHANGE);
    assign busy        = disp_req | chg_req;
    assign disp_id     = disp_id_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_beverage_vend_ctrl.sv
// Bench for beverage_vend_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_beverage_vend_ctrl;

    localparam int PRICE = 3;
    localparam int MAXU  = 6;
    localparam int NPROD = 3;

    logic             clk;
    logic             rst_n;
    logic [1:0]       coin;
    logic             cancel;
    logic             sel_valid;
    logic [1:0]       sel_id;
    logic [NPROD-1:0] stock_empty;
    logic             disp_ack;
    logic             chg_ack;
    logic             disp_req;
    logic [1:0]       disp_id;
    logic             chg_req;
    logic             coin_reject;
    logic             sel_err;
    logic [2:0]       credit;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: credit count plus "dispensing" / "paying back" flags
    int m_credit;
    bit m_vending;
    bit m_paying;
    int m_id;
    bit m_rej;
    bit m_err;

    beverage_vend_ctrl #(
        .PRICE_UNITS (PRICE),
        .MAX_UNITS   (MAXU),
        .NUM_PRODUCTS(NPROD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coin       (coin),
        .cancel     (cancel),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .stock_empty(stock_empty),
        .disp_ack   (disp_ack),
        .chg_ack    (chg_ack),
        .disp_req   (disp_req),
        .disp_id    (disp_id),
        .chg_req    (chg_req),
        .coin_reject(coin_reject),
        .sel_err    (sel_err),
        .credit     (credit),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit  = 0;
        m_vending = 0;
        m_paying  = 0;
        m_id      = 0;
        m_rej     = 0;
        m_err     = 0;
    endtask

    // one clock of the vending rules, applied to the model
    task automatic model_step(input int c, input bit cn, input bit sv, input int sid,
                              input bit da, input bit ca);
        int  v;
        bit  in_use;
        bit  cancel_now;
        bit  ok;
        v      = (c == 1) ? 1 : (c == 2) ? 2 : 0;
        in_use = m_vending || m_paying;
        m_rej  = 0;
        m_err  = 0;
        if (!in_use) begin
            cancel_now = cn && (m_credit > 0);
            ok = sv && !cancel_now && (m_credit >= PRICE) && (sid < NPROD);
            if (ok) ok = !stock_empty[sid];
            if (sv && !cancel_now && !ok) m_err = 1;
            if (c == 3) m_rej = 1;
            else if (v > 0) begin
                if (ok || cancel_now) m_rej = 1;
                else if (m_credit + v <= MAXU) m_credit += v;
                else m_rej = 1;
            end
            if (ok) begin
                m_credit -= PRICE;
                m_id      = sid;
                m_vending = 1;
            end else if (cancel_now) begin
                m_paying = 1;
            end
        end else begin
            if (c != 0) m_rej = 1;
            if (m_vending) begin
                if (da) begin
                    m_vending = 0;
                    m_paying  = (m_credit > 0);
                end
            end else if (ca) begin
                m_credit--;
                if (m_credit == 0) m_paying = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("credit",      int'(credit),      m_credit);
        check("disp_req",    int'(disp_req),    int'(m_vending));
        check("disp_id",     int'(disp_id),     m_id);
        check("chg_req",     int'(chg_req),     int'(m_paying));
        check("busy",        int'(busy),        int'(m_vending || m_paying));
        check("coin_reject", int'(coin_reject), int'(m_rej));
        check("sel_err",     int'(sel_err),     int'(m_err));
    endtask

    // drive one cycle of inputs, advance the model, then compare
    task automatic step(input logic [1:0] c, input logic cn, input logic sv,
                        input logic [1:0] sid, input logic da, input logic ca);
        @(negedge clk);
        coin      = c;
        cancel    = cn;
        sel_valid = sv;
        sel_id    = sid;
        disp_ack  = da;
        chg_ack   = ca;
        @(posedge clk);
        model_step(int'(c), cn, sv, int'(sid), da, ca);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic put_coin(input logic [1:0] c);
        step(c, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic select(input logic [1:0] sid);
        step(2'b00, 1'b0, 1'b1, sid, 1'b0, 1'b0);
    endtask

    task automatic ack_disp();
        step(2'b00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic ack_chg();
        step(2'b00, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic do_cancel();
        step(2'b00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        coin        = 2'b00;
        cancel      = 1'b0;
        sel_valid   = 1'b0;
        sel_id      = 2'd0;
        stock_empty = '0;
        disp_ack    = 1'b0;
        chg_ack     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit",   int'(credit),      0);
        check("rst_disp_req", int'(disp_req),    0);
        check("rst_chg_req",  int'(chg_req),     0);
        check("rst_reject",   int'(coin_reject), 0);
        check("rst_sel_err",  int'(sel_err),     0);
        @(negedge clk);
        rst_n = 1'b1;

        // three 50 ct coins, buy product 2, no change due
        put_coin(2'b01); check("seq1_c1", int'(credit), 1);
        put_coin(2'b01); check("seq1_c2", int'(credit), 2);
        put_coin(2'b01); check("seq1_c3", int'(credit), 3);
        select(2'd2);
        check("seq1_req", int'(disp_req), 1);
        check("seq1_id",  int'(disp_id),  2);
        check("seq1_cr",  int'(credit),   0);
        idle();
        ack_disp();
        check("seq1_idle", int'(busy),    0);
        check("seq1_nochg", int'(chg_req), 0);

        // two 1 EUR coins, buy product 0, one unit of change
        put_coin(2'b10);
        put_coin(2'b10); check("seq2_c4", int'(credit), 4);
        select(2'd0);
        ack_disp();
        check("seq2_chg", int'(chg_req), 1);
        ack_chg();
        check("seq2_done", int'(chg_req), 0);
        check("seq2_cr0",  int'(credit),  0);
        ack_chg();

        // refused selections
        put_coin(2'b10);
        select(2'd0);
        check("low_err", int'(sel_err), 1);
        check("low_cr",  int'(credit),  2);
        put_coin(2'b01);
        stock_empty = 3'b010;
        select(2'd1);
        check("empty_err", int'(sel_err), 1);
        select(2'd3);
        check("range_err", int'(sel_err), 1);
        stock_empty = '0;
        do_cancel();
        repeat (3) ack_chg();
        select(2'd1);
        check("idle_err", int'(sel_err), 1);

        // coin rejects
        repeat (3) put_coin(2'b10);
        put_coin(2'b01);
        check("full_rej", int'(coin_reject), 1);
        check("full_cr",  int'(credit),      6);
        do_cancel();
        repeat (6) ack_chg();
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        put_coin(2'b10);
        check("five_rej", int'(coin_reject), 1);
        check("five_cr",  int'(credit),      5);
        do_cancel();
        repeat (5) ack_chg();
        put_coin(2'b11);
        check("inv_rej", int'(coin_reject), 1);
        put_coin(2'b10); put_coin(2'b01);
        select(2'd0);
        put_coin(2'b01);
        check("vend_rej", int'(coin_reject), 1);
        check("vend_cr",  int'(credit),      0);
        ack_disp();

        // same-cycle interactions
        put_coin(2'b10); put_coin(2'b01);
        step(2'b10, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("mix_vend", int'(disp_req),    1);
        check("mix_rej",  int'(coin_reject), 1);
        check("mix_cr",   int'(credit),      0);
        ack_disp();
        put_coin(2'b10); put_coin(2'b10);
        step(2'b00, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        check("cxl_chg", int'(chg_req), 1);
        check("cxl_err", int'(sel_err), 0);
        repeat (4) ack_chg();
        check("cxl_idle", int'(busy), 0);

        // asynchronous reset in the middle of a vend
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b01);
        select(2'd0);
        check("pre_rst_req", int'(disp_req), 1);
        check("pre_rst_cr",  int'(credit),   2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", int'(disp_req), 0);
        check("arst_cr",  int'(credit),   0);
        check("arst_chg", int'(chg_req),  0);
        check("arst_id",  int'(disp_id),  0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        put_coin(2'b01);
        check("post_rst_cr", int'(credit), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            if ($urandom_range(0, 31) == 0) stock_empty = NPROD'($urandom);
            c = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            step(c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/beverage_vend_ctrl.md
Name: beverage_vend_ctrl

Overview:
- Sequences one vending transaction: accepts coins into a credit counter, validates product selection against price and stock, and drives the dispenser handshake.
- Returns leftover credit as 50-cent units through a change-hopper handshake.
- Sits between the coin acceptor/keypad and the dispenser/hopper.
- Coin encoding matches the existing coin path: 00 none, 01 = 50 ct, 10 = 1 EUR, 11 = invalid.

Parameters:
PRICE_UNITS, 3, product price in 50-cent units (3 = 1.50 EUR); must be ≥1 and ≤ MAX_UNITS
MAX_UNITS, 6, maximum credit in 50-cent units; must be ≤ 7
NUM_PRODUCTS, 4, number of products; sel_id/disp_id are 2 bits wide, so NUM_PRODUCTS ≤ 4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin  in  2  coin event, valid for one cycle per coin; 00 none, 01 50ct, 10 1EUR, 11 invalid
cancel  in  1  return-credit request, one-cycle pulse
sel_valid  in  1  product selection strobe
sel_id  in  2  selected product index
stock_empty  in  NUM_PRODUCTS  per-product empty flag
disp_ack  in  1  dispenser done
chg_ack  in  1  hopper ejected one 50-cent unit
disp_req  out  1  dispense request
disp_id  out  2  product to dispense, stable while disp_req=1
chg_req  out  1  request one 50-cent unit from hopper
coin_reject  out  1  one-cycle pulse: route the coin just presented to the return slot
sel_err  out  1  one-cycle pulse: selection refused
credit  out  3  current credit in 50-cent units
busy  out  1  high in VEND or CHANGE

Behaviour:
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE. Encoding is free.
- Reset (async, rst_n=0) → IDLE, credit=0. All outputs 0 immediately: disp_req, disp_id, chg_req, coin_reject, sel_err. Reset mid-VEND/CHANGE aborts; credit is lost.
- coin_reject and sel_err are registered: they pulse in the cycle after the triggering input.
- Coin in IDLE/CREDIT:
  - Value v = 1 (01) or 2 (10).
  - If credit+v ≤ MAX_UNITS: credit += v next cycle, state → CREDIT.
  - Else: coin_reject, credit unchanged.
  - coin=11 → coin_reject in any state.
- Coin in VEND/CHANGE: any nonzero coin → coin_reject, credit unchanged.
- sel_valid in CREDIT, cancel=0:
  - Accepted if credit ≥ PRICE_UNITS, sel_id < NUM_PRODUCTS, and stock_empty[sel_id]=0.
  - On accept: credit -= PRICE_UNITS, disp_id latched, → VEND.
  - Otherwise: sel_err, state/credit unchanged.
- sel_valid in IDLE → sel_err. sel_valid in VEND/CHANGE → ignored, no sel_err.
- Simultaneous coin + accepted selection: selection is evaluated on the registered credit; the coin is rejected (coin_reject).
- Simultaneous coin + refused selection: coin handled normally.
- cancel in CREDIT → CHANGE. It beats sel_valid in the same cycle (no sel_err); a same-cycle coin is rejected.
- cancel in IDLE/VEND/CHANGE → ignored.
- VEND:
  - disp_req=1 for every VEND cycle; disp_ack is sampled only in VEND.
  - On disp_ack=1: next state CHANGE if credit>0, else IDLE; disp_req is 0 from that next cycle.
  - There is no timeout.
- CHANGE:
  - chg_req=1 for every CHANGE cycle.
  - Each cycle with chg_ack=1: credit -= 1.
  - When credit goes 1→0 → IDLE in the same update; chg_req=0 the following cycle.
  - chg_ack outside CHANGE is ignored.
- Width rules:
  - credit never exceeds MAX_UNITS and never underflows.
  - The credit+v check uses a 4-bit sum (no wrap).
- Maximum transaction latency from accepted selection to disp_req=1: 1 cycle.

Test Plan:
- Reset, coin 01,01,01 (one cycle each), sel_valid id=2 → credit 1,2,3; disp_req=1 with disp_id=2 one cycle after selection; credit=0; disp_ack → IDLE, no chg_req.
- Coins 10,10 (credit 4), select id=0, disp_ack → CHANGE; chg_req=1; chg_ack once → credit 0, IDLE; exactly one chg_ack is consumed.
- Credit 2, sel_valid → sel_err pulse, credit stays 2. Credit 3 with stock_empty[1]=1, select id=1 → sel_err. Credit 3, sel_id=3 with NUM_PRODUCTS=3 → sel_err. sel_valid in IDLE → sel_err.
- Credit 6, coin 01 → coin_reject, credit 6. Credit 5, coin 10 → coin_reject. coin 11 in IDLE → coin_reject. Coin 01 during VEND → coin_reject, credit unchanged.
- Same cycle: credit 3, coin 10 + valid selection → VEND, coin_reject, credit 0. Same cycle: cancel + sel_valid at credit 4 → CHANGE, no sel_err; 4 chg_acks → IDLE.
- Assert rst_n low while disp_req=1 and credit=2 → disp_req, credit, and chg_req are 0 before the next clk edge; after release, state IDLE and coins accepted normally.
